conv_encoder_par: RTL

Parametrised rate-1/2 convolutional encoder with constraint length K and generator polynomials set by parameters. It runs on a single clock and uses valid/ready handshakes on both sides, so no separate 2x code clock is needed. It accepts one information bit per input handshake and emits the two code bits serially (c0 then c1). Frames are delimited by `in_last`. Optional zero-tail termination returns the trellis to state 0 at frame end. It sits between the bit source (e.g. M-series generator) and the channel/modulator stage.

---
 rtl/conv_encoder_par.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/conv_encoder_par.sv
`default_nettype none
// ============================================================================
//  Module   : conv_encoder_par
//  Purpose  : Rate-1/2 convolutional encoder with parametrised constraint
//             length and generators. Runs on one clock. Each accepted
//             information bit produces two serial code bits (c0 then c1).
//             Zero-tail termination is optional.
//  Ports    : clk, rst (async, active-high)
//             in_valid / in_ready / in_bit / in_last   - information bit side
//             out_valid / out_ready / out_bit / out_last - code bit side
//             busy - high whenever the encoder is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module conv_encoder_par #(
    parameter int unsigned    K       = 3,
    parameter logic [K-1:0]   G0      = 3'b101,
    parameter logic [K-1:0]   G1      = 3'b111,
    parameter bit             TAIL_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic out_bit,
    output logic out_last,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_C0   = 2'd1,
        ST_C1   = 2'd2
    } state_t;

    // K is at most 16, so the tail count never exceeds 15.
    localparam logic [3:0] c_TAIL_INIT = 4'(K - 1);

    state_t       state_q, state_d;
    logic [K-2:0] s_q, s_d;
    logic [3:0]   tail_cnt_q, tail_cnt_d;
    logic         last_q, last_d;
    logic         c1_q, c1_d;
    logic         out_valid_q, out_valid_d;
    logic         out_bit_q, out_bit_d;
    logic         out_last_q, out_last_d;

    logic         w_tail_pending;
    logic         w_b;
    logic [K-1:0] w_window;
    logic         w_c0;
    logic         w_c1;
    logic         w_take_bit;
    logic         w_take_tail;

    // A pending tail bit always wins over new input in C1, so the window
    // is fed a 0 in that case regardless of in_bit.
    assign w_tail_pending = (tail_cnt_q != 4'd0);
    assign w_b            = (state_q == ST_C1 && w_tail_pending) ? 1'b0 : in_bit;
    assign w_window       = {w_b, s_q};
    assign w_c0           = ^(w_window & G0);
    assign w_c1           = ^(w_window & G1);

    // in_ready is gated by rst so that it reads 0 while reset is held,
    // even though the state register already sits in IDLE.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = ~rst;
            ST_C1:   in_ready = out_ready & ~w_tail_pending & ~last_q;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        tail_cnt_d  = tail_cnt_q;
        last_d      = last_q;
        c1_d        = c1_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_last_d  = out_last_q;
        w_take_bit  = 1'b0;
        w_take_tail = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_take_bit = 1'b1;
                end
            end
            ST_C0: begin
                if (out_ready) begin
                    state_d   = ST_C1;
                    out_bit_d = c1_q;
                    // Frame end is the c1 of the last tail bit (tail mode)
                    // or of the last data bit (no tail: count stays 0).
                    out_last_d = last_q & ~w_tail_pending;
                end
            end
            ST_C1: begin
                if (out_ready) begin
                    if (w_tail_pending) begin
                        w_take_tail = 1'b1;
                    end else if (in_valid && !last_q) begin
                        w_take_bit = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_bit_d   = 1'b0;
                        out_last_d  = 1'b0;
                        last_d      = 1'b0;
                        // Without a tail the trellis is forced home here;
                        // with a tail it is already zero.
                        if (last_q) begin
                            s_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_take_bit || w_take_tail) begin
            state_d     = ST_C0;
            out_valid_d = 1'b1;
            out_bit_d   = w_c0;
            out_last_d  = 1'b0;
            c1_d        = w_c1;
            s_d         = w_window[K-1:1];
            if (w_take_bit) begin
                last_d     = in_last;
                tail_cnt_d = (TAIL_EN && in_last) ? c_TAIL_INIT : 4'd0;
            end else begin
                tail_cnt_d = tail_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            tail_cnt_q  <= 4'd0;
            last_q      <= 1'b0;
            c1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            tail_cnt_q  <= tail_cnt_d;
            last_q      <= last_d;
            c1_q        <= c1_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
